// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan register bank.
//   scan_state_e : unload sequencer states
//   cnt_width()  : width of the shift counter for an L-bit segment
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } scan_state_e;

  // Counter holds 0..L-1; sized for L+1 values so L=1 still gets one bit.
  function automatic int cnt_width(input int l);
    return $clog2(l + 1);
  endfunction

endpackage

// File: rtl/scan_reg_bank_if.sv
// Bus bundle for scan_reg_bank.
//   d/load_en      : functional capture
//   se/si/so       : manual scan shift, one si/so bit per chain
//   scan_start     : automatic capture+unload request
//   q              : register contents
//   scan_busy/done : sequencer status
interface scan_reg_bank_if #(
  parameter int WIDTH  = 16,
  parameter int CHAINS = 2
);
  logic [WIDTH-1:0]  d;
  logic              load_en;
  logic              se;
  logic [CHAINS-1:0] si;
  logic              scan_start;
  logic [WIDTH-1:0]  q;
  logic [CHAINS-1:0] so;
  logic              scan_busy;
  logic              scan_done;

  modport master (
    output d, load_en, se, si, scan_start,
    input  q, so, scan_busy, scan_done
  );

  modport slave (
    input  d, load_en, se, si, scan_start,
    output q, so, scan_busy, scan_done
  );
endinterface

// File: rtl/scan_seg.sv
// One L-bit scan segment.
//   clock/reset : rising-edge clock, synchronous active-high reset
//   shift       : move every bit one place toward bit 0, si enters at bit L-1
//   load        : capture d (shift has priority)
//   q           : segment contents, so = q[0]
module scan_seg
  import scan_pkg::*;
#(
  parameter int L = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shift,
  input  logic         load,
  input  logic         si,
  input  logic [L-1:0] d,
  output logic [L-1:0] q,
  output logic         so
);

  logic [L-1:0] seg_d, seg_q;

  always_comb begin
    seg_d = seg_q;
    if (shift) begin
      // Right shift then overwrite the top bit: valid for L=1 as well.
      seg_d        = seg_q >> 1;
      seg_d[L-1]   = si;
    end else if (load) begin
      seg_d = d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) seg_q <= '0;
    else       seg_q <= seg_d;
  end

  assign q  = seg_q;
  assign so = seg_q[0];

endmodule

// File: rtl/scan_reg_bank.sv
// Multi-chain scan register bank with capture-then-unload sequencer.
//   clock/reset : rising-edge clock, synchronous active-high reset
//   bus (slave) : d/load_en functional load, se/si manual shift,
//                 scan_start launches capture + L-cycle unload,
//                 q/so register taps, scan_busy/scan_done status.
// The register is split into CHAINS segments of L = WIDTH/CHAINS bits;
// chain c owns q[c*L +: L] and so[c] = q[c*L].
module scan_reg_bank
  import scan_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHAINS = 2
) (
  input  logic           clock,
  input  logic           reset,
  scan_reg_bank_if.slave bus
);

  localparam int L     = WIDTH / CHAINS;
  localparam int CNT_W = cnt_width(L);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  generate
    if (WIDTH % CHAINS != 0) begin : g_bad_split
      $error("scan_reg_bank: WIDTH must be a multiple of CHAINS");
    end
  endgenerate

  scan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // Sequencer owns the segments in CAPTURE/SHIFT; manual controls only act
  // in IDLE, and se beats load_en there.
  logic seg_shift, seg_load;
  always_comb begin
    seg_shift = (state_q == SHIFT) || (state_q == IDLE && bus.se);
    seg_load  = (state_q == CAPTURE) ||
                (state_q == IDLE && !bus.se && bus.load_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.scan_start) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          state_q <= SHIFT;
          cnt_q   <= '0;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [CHAINS-1:0][L-1:0] seg_q;
  logic [CHAINS-1:0]        seg_so;

  generate
    for (genvar c = 0; c < CHAINS; c++) begin : g_seg
      scan_seg #(.L(L)) u_seg (
        .clock (clock),
        .reset (reset),
        .shift (seg_shift),
        .load  (seg_load),
        .si    (bus.si[c]),
        .d     (bus.d[c*L +: L]),
        .q     (seg_q[c]),
        .so    (seg_so[c])
      );
    end
  endgenerate

  assign bus.q         = seg_q;
  assign bus.so        = seg_so;
  assign bus.scan_busy = busy_q;
  assign bus.scan_done = done_q;

endmodule

// File: tb/tb_scan_reg_bank.sv
module tb_scan_reg_bank;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  scan_reg_bank_if #(.WIDTH(8), .CHAINS(2)) bus ();

  scan_reg_bank #(.WIDTH(8), .CHAINS(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic       se;
    logic       st;
    logic [1:0] si;
    logic [7:0] d;
    logic [7:0] q;
    logic [1:0] so;
    logic       busy;
    logic       done;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ld, input logic se, input logic st,
                       input logic [1:0] si, input logic [7:0] d);
    reset          = rst;
    bus.load_en    = ld;
    bus.se         = se;
    bus.scan_start = st;
    bus.si         = si;
    bus.d          = d;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] q, input logic [1:0] so,
                         input logic busy, input logic done);
    chk({tag, " q"},    bus.q,         q);
    chk({tag, " so"},   bus.so,        so);
    chk({tag, " busy"}, bus.scan_busy, busy);
    chk({tag, " done"}, bus.scan_done, done);
  endtask

  function automatic vec_t mk(input logic rst, input logic ld, input logic se, input logic st,
                              input logic [1:0] si, input logic [7:0] d, input logic [7:0] q,
                              input logic [1:0] so, input logic busy, input logic done);
    vec_t v;
    v.rst = rst; v.ld = ld; v.se = se; v.st = st; v.si = si; v.d = d;
    v.q = q; v.so = so; v.busy = busy; v.done = done;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    logic [7:0] pat;
    int         cyc, busy_cnt, done_at;

    //             rst ld se st si     d      q      so    busy done
    vecs[0]  = mk(1, 1, 0, 0, 2'b00, 8'hFF, 8'h00, 2'b00, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 2'b00, 8'hFF, 8'h00, 2'b00, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 2'b00, 8'hA5, 8'hA5, 2'b01, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 2'b00, 8'h00, 8'hA5, 2'b01, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 2'b11, 8'h00, 8'hDA, 2'b10, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 2'b00, 8'h3C, 8'h3C, 2'b10, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 2'b01, 8'h3C, 8'h1E, 2'b10, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 2'b00, 8'h3C, 8'h1E, 2'b10, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 2'b00, 8'h3C, 8'h3C, 2'b10, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 2'b00, 8'h3C, 8'h16, 2'b10, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 2'b00, 8'h3C, 8'h03, 2'b01, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 2'b00, 8'h3C, 8'h01, 2'b01, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 2'b00, 8'h3C, 8'h00, 2'b00, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 2'b00, 8'h3C, 8'h00, 2'b00, 0, 0);

    drive(1, 0, 0, 0, 2'b00, 8'h00);
    #1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].se, vecs[i].st, vecs[i].si, vecs[i].d);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].so, vecs[i].busy, vecs[i].done);
    end

    // Inputs during SHIFT and DONE are ignored; no second sequence.
    drive(0, 0, 0, 1, 2'b00, 8'h3C);
    step(); chk_all("ign t1", 8'h00, 2'b00, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 8'h3C);
    step(); chk_all("ign t2", 8'h3C, 2'b10, 1, 0);
    step(); chk_all("ign t3", 8'h16, 2'b10, 1, 0);
    drive(0, 1, 1, 1, 2'b00, 8'hFF);
    step(); chk_all("ign t4", 8'h03, 2'b01, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 8'hFF);
    step(); chk_all("ign t5", 8'h01, 2'b01, 1, 0);
    step(); chk_all("ign t6", 8'h00, 2'b00, 0, 1);
    drive(0, 0, 0, 1, 2'b00, 8'hFF);   // start while in DONE
    step(); chk_all("ign t7", 8'h00, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b00, 8'hFF);
    step(); chk_all("ign t8", 8'h00, 2'b00, 0, 0);

    // Reset in the second SHIFT cycle discards the unload.
    drive(0, 0, 0, 1, 2'b00, 8'h3C);
    step(); chk("rst busy1", bus.scan_busy, 1'b1);
    drive(0, 0, 0, 0, 2'b00, 8'h3C);
    step(); chk("rst cap q", bus.q, 8'h3C);
    step(); chk("rst sh2 q", bus.q, 8'h16);
    reset = 1'b1;
    step(); chk_all("rst hit", 8'h00, 2'b00, 0, 0);
    reset = 1'b0;
    step(); chk_all("rst after", 8'h00, 2'b00, 0, 0);

    // Full sequence after reset, timed with a bounded wait.
    pat = 8'hA5;
    drive(0, 0, 0, 1, 2'b11, pat);
    step();
    bus.scan_start = 1'b0;
    cyc      = 1;
    busy_cnt = bus.scan_busy ? 1 : 0;
    done_at  = 0;
    while (cyc < 20 && done_at == 0) begin
      step();
      cyc++;
      if (bus.scan_busy) busy_cnt++;
      if (cyc >= 2 && cyc <= 5)
        chk($sformatf("seq so k%0d", cyc - 2), bus.so, {pat[4 + cyc - 2], pat[cyc - 2]});
      if (bus.scan_done) done_at = cyc;
    end
    chk("seq done cycle", done_at, 6);
    chk("seq busy len", busy_cnt, 5);
    chk("seq final q", bus.q, 8'hFF);
    step();
    chk("seq done pulse", bus.scan_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_reg_bank.md
# scan_reg_bank

Parametrised multi-chain scan register bank with a built-in unload sequencer. It generalises the single mux-D scan flop to a WIDTH-bit register split into CHAINS parallel scan segments. It supports functional load/hold, manual per-cycle scan shift, and an autonomous capture-then-unload sequence with a start/busy/done handshake. It sits between functional datapath registers and the test/debug access logic.

## Interface
- WIDTH, 16: total register bits.
- CHAINS, 2: number of parallel scan chains. WIDTH % CHAINS must be 0, otherwise elaboration fails. Segment length L = WIDTH/CHAINS.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- d  in  WIDTH  functional data in.
- load_en  in  1  functional capture enable.
- se  in  1  manual scan-shift enable.
- si  in  CHAINS  scan input, one bit per chain.
- scan_start  in  1  request for an automatic capture+unload sequence (single-cycle pulse).
- q  out  WIDTH  register contents.
- so  out  CHAINS  scan output; so[c] = q[c*L].
- scan_busy  out  1  sequence in progress.
- scan_done  out  1  one-cycle completion pulse.

## Operation
- Chain c owns q[c*L +: L]. On a shift, every bit moves one place toward the LSB of its segment, q[c*L+L-1] takes si[c], and so[c] presents the current q[c*L]. Segments never exchange bits.
- FSM states: IDLE, CAPTURE, SHIFT, DONE.
  - IDLE → CAPTURE when scan_start=1.
  - CAPTURE → SHIFT after 1 cycle. q is loaded from d and the shift counter cleared.
  - SHIFT → DONE after exactly L shift edges. The counter is $clog2(L+1) bits wide and counts 0..L-1.
  - DONE → IDLE after 1 cycle. q holds during DONE.
- Update priority per edge: reset > FSM in CAPTURE/SHIFT > se > load_en > hold.
- scan_start is accepted in IDLE only. It is ignored in CAPTURE, SHIFT and DONE, with no queuing.
- se and load_en are ignored while the FSM is not IDLE.
- scan_busy=1 in CAPTURE and SHIFT. scan_done=1 in DONE only.
- Reset at any point, including mid-SHIFT, forces state IDLE, q=0, counter=0, scan_busy=0 and scan_done=0 on that edge. The partial unload is discarded.
- Reset values: q=0, so=0, scan_busy=0, scan_done=0.

## Timing
- Functional load: load_en=1 in cycle t gives q=d(t) in cycle t+1.
- Manual shift: se=1 in cycle t shifts once, and q/so reflect it in t+1.
- Automatic sequence with scan_start in cycle t:
  - scan_busy=1 in cycles t+1 through t+1+L.
  - Capture edge at the end of t+1.
  - so carries captured bit k of each segment (LSB first) in cycle t+2+k, for k=0..L-1.
  - scan_done=1 in cycle t+2+L; next accepted start is in t+3+L.
- Total latency from start to done is L+2 cycles.
- L=1 (WIDTH=CHAINS) is legal: a single SHIFT cycle.
- All outputs are registered or direct register taps, with no combinational path from inputs to outputs.

## Structure
- Shared package scan_pkg:
  - state typedef enum (IDLE, CAPTURE, SHIFT, DONE);
  - a localparam function for the counter width.
- Sub-module scan_seg: one L-bit segment with shift/load/hold controls and si/so. It is instantiated CHAINS times in a generate loop.
- The FSM and counter live in scan_reg_bank.

## Test plan
All scenarios use WIDTH=8, CHAINS=2 (L=4).
1. Reset: hold reset 2 cycles with load_en=1, d=8'hFF → q=8'h00, so=2'b00, scan_busy=0, scan_done=0.
2. Functional load: load_en=1, d=8'hA5 → q=8'hA5 next cycle. Then load_en=0 with d=8'h00 → q stays 8'hA5. se=1 with load_en=1 → shift wins.
3. Manual shift: from q=8'hA5, so=2'b01; apply se=1, si=2'b11 for one cycle → q=8'hDA, so=2'b10.
4. Auto unload: d=8'h3C, si=2'b00, pulse scan_start.
   - scan_busy high 5 cycles.
   - so[0] streams 0,0,1,1 and so[1] streams 1,1,0,0.
   - scan_done pulses 1 cycle, then q=8'h00.
5. Ignored inputs: during SHIFT, pulse scan_start and assert se=1, load_en=1 → sequence length and so stream unchanged, and no second sequence starts.
6. Reset mid-operation: assert reset in the 2nd SHIFT cycle → next cycle q=0, scan_busy=0, no scan_done. A subsequent scan_start runs a full L+2-cycle sequence.
